// File: rtl/keypad_scan_onehot.sv
// 4x4 keypad scanner: drives rows one at a time, assembles a 16-key frame,
// rejects multi-key frames and debounces across frames into a held one-hot word.
module keypad_scan_onehot #(
  parameter int unsigned CLK_DIV         = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        key_pulse
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_FRAMES);

  logic [3:0]      col_meta_q, col_sync_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      row_idx_q, row_idx_d;
  logic [15:0]     frame_q, frame_d;
  logic            eval_q, eval_d;
  logic [15:0]     cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     onehot_q, onehot_d;
  logic            key_valid_q, key_valid_d;
  logic            key_pulse_q, key_pulse_d;
  logic            tick;
  logic            frame_ok;

  // Synchronizer idles at all-ones so nothing looks pressed out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
    end
  end

  assign tick = (div_q == DivLast);

  always_comb begin
    div_d     = tick ? '0 : div_q + 1'b1;
    row_idx_d = row_idx_q;
    frame_d   = frame_q;
    eval_d    = 1'b0;
    if (tick) begin
      frame_d[{row_idx_q, 2'b00} +: 4] = ~col_sync_q;
      row_idx_d = row_idx_q + 2'd1;
      eval_d    = (row_idx_q == 2'd3);
    end
  end

  assign row = ~(4'b0001 << row_idx_q);

  // Zero or a single set bit; anything else is multi-key or ghosting.
  assign frame_ok = ((frame_q & (frame_q - 16'd1)) == 16'd0);

  always_comb begin
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    onehot_d    = onehot_q;
    key_valid_d = key_valid_q;
    key_pulse_d = 1'b0;
    if (eval_q) begin
      if (!frame_ok) begin
        cnt_d = '0;
      end else if (frame_q != cand_q) begin
        cand_d = frame_q;
        cnt_d  = CntW'(1);
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (frame_ok && (cnt_d == CntMax) && (cand_d != onehot_q)) begin
        onehot_d    = cand_d;
        key_valid_d = |cand_d;
        key_pulse_d = |cand_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      row_idx_q   <= 2'd0;
      frame_q     <= '0;
      eval_q      <= 1'b0;
      cand_q      <= '0;
      cnt_q       <= '0;
      onehot_q    <= '0;
      key_valid_q <= 1'b0;
      key_pulse_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      row_idx_q   <= row_idx_d;
      frame_q     <= frame_d;
      eval_q      <= eval_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      onehot_q    <= onehot_d;
      key_valid_q <= key_valid_d;
      key_pulse_q <= key_pulse_d;
    end
  end

  assign onehot    = onehot_q;
  assign key_valid = key_valid_q;
  assign key_pulse = key_pulse_q;

endmodule

// File: doc/keypad_scan_onehot.md
Name: keypad_scan_onehot

Overview:
- Scanner at the front of the 4x4 keypad path; the producer of the 16-bit one-hot key word that the downstream onehot-to-binary digit encoder consumes.
- Drives the keypad rows one at a time and samples the columns; assembles a 16-key frame; rejects multi-key frames; debounces across frames.
- Presents a held one-hot key word plus a single-cycle new-key strobe.

Parameters:
- CLK_DIV, 1000: clk cycles per row slot; legal range ≥4.
- DEBOUNCE_FRAMES, 4: consecutive identical frames needed to accept a change; legal range ≥1.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- row  output  4  keypad row drive, active-low one-hot; exactly one bit low at all times.
- col  input  4  keypad column sense, active-low with external pull-ups; asynchronous to clk.
- onehot  output  16  debounced key word; bit index = 4*row_index + col_index; all-zero = no key.
- key_valid  output  1  high while onehot is non-zero.
- key_pulse  output  1  one-cycle strobe when onehot changes to a new non-zero value.

Behaviour:
- Reset (async assert, sync release) values:
  - row = 4'b1110 (row 0).
  - onehot = 0; key_valid = 0; key_pulse = 0.
  - divider, row index, frame buffer, candidate word and debounce counter all 0.
- col passes through a 2-flop synchronizer before use; it has no other filtering.
- Divider: counts 0..CLK_DIV-1. tick = 1 on the cycle the count equals CLK_DIV-1; the count then wraps to 0.
- On each tick:
  - Store ~col_sync into frame bits [4*r+3 : 4*r], where r = current row index.
  - Advance r = (r+1) mod 4 and drive the new row on the next cycle.
  - Each row is therefore held low for CLK_DIV cycles before it is sampled, which covers the settle and synchronizer delay.
- Frame completes on the tick where r = 3; the frame word is evaluated on the following cycle (cycle E).
- Frame validity: valid if the word is zero or has exactly one bit set. A word with two or more bits set (multi-key or ghosting) is invalid.
- Debounce, evaluated at cycle E:
  - Invalid frame: debounce counter = 0; candidate unchanged; outputs unchanged.
  - Valid frame ≠ candidate: candidate = frame; counter = 1.
  - Valid frame = candidate: counter increments, saturating at DEBOUNCE_FRAMES.
  - Accept when counter reaches DEBOUNCE_FRAMES (including the same update when DEBOUNCE_FRAMES = 1) and candidate ≠ onehot. On accept, the next cycle sets onehot = candidate and key_valid = (candidate ≠ 0).
  - key_pulse = 1 in that same cycle only if candidate ≠ 0.
- Release: an accepted all-zero candidate clears onehot and key_valid; no pulse.
- Key-to-key change without an intervening release: the new key is accepted once stable and pulses.
- A held key never re-pulses.
- Glitch shorter than DEBOUNCE_FRAMES frames: no output change.
- Reset mid-scan: the frame in progress is discarded and scanning restarts at row 0.
- Latency: a stable press is reported no later than (DEBOUNCE_FRAMES+1)*4*CLK_DIV + 4 cycles after the column edge.

Test Plan:
- CLK_DIV=4, DEBOUNCE_FRAMES=2; model asserts col[1] low whenever row[2] is driven low (key index 9) -> onehot=16'h0200 with key_pulse high for exactly 1 cycle; key_valid then stays high with no further pulses while the key is held.
- Release key 9 and hold released for 3 frames -> onehot=16'h0000, key_valid=0, key_pulse never asserts.
- Hold key 3 (row 0, col 3) for only 1 frame, then release -> onehot stays 0 and no pulse.
- Press key 5 and key 6 together for 5 frames -> onehot unchanged from its prior value; the debounce counter stays 0.
- Hold key 15, then switch directly to key 14 with no release -> onehot goes 16'h8000 then 16'h4000, with one pulse at each change.
- Assert rst_n low mid-frame while key 7 is held -> immediately onehot=0 and row=4'b1110; after release, onehot=16'h0080 is reported within (2+1)*16+4 cycles.
